ram_fifo_ctrl: RTL and testbench

- FIFO controller that sits directly upstream of ram_true_dual_port.
- Port A is the write side: drives we_a, addr_a and data_a.
- Port B is the read side: drives addr_b and consumes the registered q_b.
- Presents valid/ready push and pop interfaces to the surrounding logic, turning the 64x8 dual-port RAM into a first-word-fall-through FIFO at one push and one pop per cycle.

---
 rtl/ram_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a 64x8 true dual-port RAM (A = write, B = read).
// Define RAM_FIFO_CTRL_HWM_EN to add the hwm (peak occupancy since reset) output.
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_b,
  input  logic [DATA_W-1:0] ram_q_b
`ifdef RAM_FIFO_CTRL_HWM_EN
  ,
  output logic [ADDR_W:0]   hwm
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   mem_cnt;
  logic [ADDR_W:0]   mem_cnt_n;
  logic [ADDR_W:0]   count_n;
  logic              fetch_pending;
  logic [1:0]        out_cnt;
  logic [1:0]        out_cnt_n;
  logic [DATA_W-1:0] buf1;
  logic              push;
  logic              pop;
  logic              fetch;
  logic              ret;

  assign wr_ready = rst_n && (count < DEPTH_C);
  assign push     = wr_valid && wr_ready;
  assign rd_valid = (out_cnt != 2'd0);
  assign pop      = rd_valid && rd_ready;
  assign ret      = fetch_pending;

  // Only fetch when the word will have a free output slot by the time it returns.
  assign fetch = (mem_cnt != '0) &&
                 (({1'b0, out_cnt} + {2'b00, fetch_pending}) < (3'd2 + {2'b00, pop}));

  assign ram_we_a   = push;
  assign ram_addr_a = wptr;
  assign ram_data_a = wr_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rptr;
  assign ram_data_b = '0;

  always_comb begin
    mem_cnt_n = mem_cnt;
    case ({push, fetch})
      2'b10:   mem_cnt_n = mem_cnt + 1'b1;
      2'b01:   mem_cnt_n = mem_cnt - 1'b1;
      default: mem_cnt_n = mem_cnt;
    endcase
  end

  always_comb begin
    out_cnt_n = out_cnt;
    if (ret && !pop)
      out_cnt_n = out_cnt + 2'd1;
    else if (!ret && pop)
      out_cnt_n = out_cnt - 2'd1;
  end

  assign count_n = mem_cnt_n + (ADDR_W + 1)'(fetch) + (ADDR_W + 1)'(out_cnt_n);

  // Pointer / occupancy registers and output-buffer head (rd_data)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr          <= '0;
      rptr          <= '0;
      mem_cnt       <= '0;
      fetch_pending <= 1'b0;
      out_cnt       <= 2'd0;
      count         <= '0;
      rd_data       <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (fetch)
        rptr <= rptr + 1'b1;
      mem_cnt       <= mem_cnt_n;
      fetch_pending <= fetch;
      out_cnt       <= out_cnt_n;
      count         <= count_n;
      if (pop && out_cnt == 2'd2)
        rd_data <= buf1;
      else if (ret && (out_cnt == 2'd0 || (pop && out_cnt == 2'd1)))
        rd_data <= ram_q_b;
    end
  end

  // Second output-buffer slot; only meaningful while out_cnt == 2
  always_ff @(posedge clk) begin
    if (ret && ((out_cnt == 2'd1 && !pop) || (out_cnt == 2'd2 && pop)))
      buf1 <= ram_q_b;
  end

`ifdef RAM_FIFO_CTRL_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hwm <= '0;
    else if (count > hwm)
      hwm <= count;
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 64x8 RAM (registered q_b) attached.
module tb_ram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              ram_we_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_data_a;
  logic              ram_we_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_data_b;
  logic [DATA_W-1:0] ram_q_b = '0;
`ifdef RAM_FIFO_CTRL_HWM_EN
  logic [ADDR_W:0]   hwm;
`endif

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b),
    .ram_q_b(ram_q_b)
`ifdef RAM_FIFO_CTRL_HWM_EN
    , .hwm(hwm)
`endif
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_word;
  int buf_over = 0;
  int addr_clash = 0;
  int cnt_dev = 0;
  int peak = 0;
  logic sim_phase = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes seen here complete at the following rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      peak = 0;
    end else begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_underflow", 1, 0);
        end else begin
          exp_word = exp_q.pop_front();
          chk("pop_data", int'(rd_data), int'(exp_word));
        end
      end
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
      if (sim_phase && ram_we_a && ram_addr_a == ram_addr_b) addr_clash++;
      if (sim_phase && count != 7'd10) cnt_dev++;
      if (dut.out_cnt > 2'd2) buf_over++;
      if (int'(count) > peak) peak = int'(count);
    end
  end

  task automatic push_one(input logic [DATA_W-1:0] d);
    int n;
    wr_valid = 1'b1;
    wr_data  = d;
    #1;
    n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("push_timeout", 0, 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    rd_ready = 1'b1;
    n = 0;
    while (count != '0 && n < budget) begin
      tick();
      n++;
    end
    rd_ready = 1'b0;
    chk(name, int'(count), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int addr_bad;

    // Reset state and gating
    tick(); tick();
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    #1;
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_we_a", int'(ram_we_a), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_wr_ready", int'(wr_ready), 1);
    chk("we_b_const", int'(ram_we_b), 0);
    chk("data_b_const", int'(ram_data_b), 0);
    tick();

    // Single word: latency from push to rd_valid
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    #1;
    chk("single_we_a", int'(ram_we_a), 1);
    chk("single_addr_a", int'(ram_addr_a), 0);
    tick();
    wr_valid = 1'b0;
    chk("single_count", int'(count), 1);
    chk("single_lat0", int'(rd_valid), 0);
    tick();
    chk("single_lat1", int'(rd_valid), 0);
    tick();
    chk("single_lat2", int'(rd_valid), 1);
    chk("single_data", int'(rd_data), 8'hAA);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("single_count_after", int'(count), 0);
    chk("single_valid_after", int'(rd_valid), 0);

    // Reset mid-stream
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'h11 * (i + 1));
      tick();
    end
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_ready", int'(wr_ready), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(rd_valid), 0);
    chk("mid_rst_ready", int'(wr_ready), 1);
    push_one(8'h77);
    rd_ready = 1'b1;
    n = 0;
    while (!rd_valid && n < 10) begin
      tick();
      n++;
    end
    chk("mid_rst_first_valid", int'(rd_valid), 1);
    chk("mid_rst_no_stale", int'(rd_data), 8'h77);
    tick();
    rd_ready = 1'b0;
    chk("mid_rst_count_end", int'(count), 0);

    // Fill to full
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    addr_bad = 0;
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      #1;
      if (ram_addr_a != 6'(i) || !ram_we_a) addr_bad++;
      tick();
    end
    wr_data = 8'hFF;
    #1;
    chk("fill_addr_seq", addr_bad, 0);
    chk("full_count", int'(count), 64);
    chk("full_wr_ready", int'(wr_ready), 0);
    chk("full_we_a", int'(ram_we_a), 0);
    chk("full_addr_wrap", int'(ram_addr_a), 0);
    tick(); tick();
    chk("full_count_hold", int'(count), 64);
    chk("full_rd_valid", int'(rd_valid), 1);
    wr_valid = 1'b0;

    // Drain with no gaps, then reuse of wrapped addresses
    rd_ready = 1'b1;
    n = 0;
    while (count != '0 && n < 200) begin
      tick();
      n++;
    end
    rd_ready = 1'b0;
    chk("drain_cycles", n, 64);
    chk("drain_valid_low", int'(rd_valid), 0);
    chk("drain_sb_empty", exp_q.size(), 0);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    #1;
    chk("reuse_addr0", int'(ram_addr_a), 0);
    tick();
    wr_data = 8'h66;
    #1;
    chk("reuse_addr1", int'(ram_addr_a), 1);
    tick();
    wr_valid = 1'b0;
    wait_empty("reuse_drain", 20);

    // Simultaneous push/pop at count=10
    for (int i = 0; i < 10; i++) push_one(8'(8'h80 + i));
    chk("sim_count_start", int'(count), 10);
    sim_phase = 1'b1;
    wr_valid  = 1'b1;
    rd_ready  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_data = 8'(8'h8A + i);
      tick();
    end
    sim_phase = 1'b0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    chk("sim_count_dev", cnt_dev, 0);
    chk("sim_addr_clash", addr_clash, 0);
    chk("sim_count_end", int'(count), 10);
    wait_empty("sim_drain", 40);

    // Backpressure with rd_ready toggling
    wr_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data  = 8'(8'hC0 + i);
      rd_ready = (i % 2 == 0);
      tick();
    end
    wr_valid = 1'b0;
    wait_empty("bp_drain", 200);
    chk("bp_sb_empty", exp_q.size(), 0);
    chk("bp_buf_over", buf_over, 0);
`ifdef RAM_FIFO_CTRL_HWM_EN
    tick();
    chk("hwm_peak", int'(hwm), peak);
    chk("hwm_full", int'(hwm), 64);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
